// File: rtl/instr_trace_unit.sv
// -----------------------------------------------------------------------------
// instr_trace_unit
//
// Follows each instruction fetch through request, grant, read-valid and
// decode, timestamps every phase against a free-running cycle counter and
// buffers the resulting trace records in a first-word fall-through FIFO that
// is drained through a valid/ready port.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   trace_en            enables starting new captures
//   instr_req/addr      fetch request and address
//   instr_grant         fetch grant
//   instr_rvalid/rdata  fetch data valid and instruction word
//   is_decoding         decode stage consumes an instruction this cycle
//   trace_valid/ready   record output handshake (head of FIFO)
//   trace_addr/data     head record address and instruction word
//   trace_t_*           head record phase timestamps
//   fifo_level          records buffered
//   overflow_count      records dropped on a full FIFO (saturating)
//   missed_count        granted fetches not captured (saturating)
//
// Build option
//   TRACE_RDATA_EN  when defined, the instruction word is stored per record
//                   and driven on trace_data; otherwise trace_data is 0.
// -----------------------------------------------------------------------------
module instr_trace_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIME_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          trace_en,
   input  logic                          instr_req,
   input  logic [ADDR_WIDTH-1:0]         instr_addr,
   input  logic                          instr_grant,
   input  logic                          instr_rvalid,
   input  logic [DATA_WIDTH-1:0]         instr_rdata,
   input  logic                          is_decoding,
   output logic                          trace_valid,
   input  logic                          trace_ready,
   output logic [ADDR_WIDTH-1:0]         trace_addr,
   output logic [DATA_WIDTH-1:0]         trace_data,
   output logic [TIME_WIDTH-1:0]         trace_t_req,
   output logic [TIME_WIDTH-1:0]         trace_t_gnt,
   output logic [TIME_WIDTH-1:0]         trace_t_rvalid,
   output logic [TIME_WIDTH-1:0]         trace_t_dec,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_WIDTH-1:0]          overflow_count,
   output logic [CNT_WIDTH-1:0]          missed_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   // state       | meaning
   // S_IDLE      | no capture in flight
   // S_WAIT_GNT  | request latched, waiting for grant
   // S_WAIT_RVAL | granted, waiting for read data
   // S_WAIT_DEC  | data latched, waiting for decode; record pushed on decode
   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_GNT  = 2'd1,
      S_WAIT_RVAL = 2'd2,
      S_WAIT_DEC  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [TIME_WIDTH-1:0] cnt_q;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [TIME_WIDTH-1:0] t_req_q, t_gnt_q, t_rv_q;

   logic ld_req, ld_gnt, ld_rv, push;
   logic start_req, missed_evt;

   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]         level_q, level_d;
   logic [CNT_WIDTH-1:0]  ovf_q, missed_q;
   logic                  pop, full, wr_en, ovf_evt;

   logic [ADDR_WIDTH-1:0] mem_addr_q  [FIFO_DEPTH];
   logic [TIME_WIDTH-1:0] mem_t_req_q [FIFO_DEPTH];
   logic [TIME_WIDTH-1:0] mem_t_gnt_q [FIFO_DEPTH];
   logic [TIME_WIDTH-1:0] mem_t_rv_q  [FIFO_DEPTH];
   logic [TIME_WIDTH-1:0] mem_t_dec_q [FIFO_DEPTH];

   assign start_req = trace_en & instr_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + TIME_WIDTH'(1);
      end
   end

   // Capture FSM: next state and latch enables
   always_comb begin
      state_d = state_q;
      ld_req  = 1'b0;
      ld_gnt  = 1'b0;
      ld_rv   = 1'b0;
      push    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               ld_req  = 1'b1;
               ld_gnt  = instr_grant;
               state_d = instr_grant ? S_WAIT_RVAL : S_WAIT_GNT;
            end
         end
         S_WAIT_GNT: begin
            if (instr_grant) begin
               ld_gnt  = 1'b1;
               state_d = S_WAIT_RVAL;
            end
         end
         S_WAIT_RVAL: begin
            if (instr_rvalid) begin
               ld_rv   = 1'b1;
               state_d = S_WAIT_DEC;
            end
         end
         S_WAIT_DEC: begin
            if (is_decoding) begin
               push    = 1'b1;
               state_d = S_IDLE;
               // The completing cycle may also start the next capture; the
               // pushed record comes from the old capture registers.
               if (start_req) begin
                  ld_req  = 1'b1;
                  ld_gnt  = instr_grant;
                  state_d = instr_grant ? S_WAIT_RVAL : S_WAIT_GNT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A grant seen in WAIT_GNT belongs to the current capture; any other
   // req&grant that is not a new start is a fetch we did not trace.
   assign missed_evt = instr_req & instr_grant & ~ld_req & (state_q != S_WAIT_GNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         t_req_q <= '0;
         t_gnt_q <= '0;
         t_rv_q  <= '0;
      end else begin
         state_q <= state_d;
         if (ld_req) begin
            addr_q  <= instr_addr;
            t_req_q <= cnt_q;
         end
         if (ld_gnt) t_gnt_q <= cnt_q;
         if (ld_rv)  t_rv_q  <= cnt_q;
      end
   end

   // Record FIFO
   assign pop     = (level_q != '0) & trace_ready;
   assign full    = (level_q == LW'(FIFO_DEPTH));
   assign wr_en   = push & (~full | pop);
   assign ovf_evt = push & full & ~pop;

   always_comb begin
      level_d = level_q;
      if (wr_en && !pop) begin
         level_d = level_q + LW'(1);
      end else if (!wr_en && pop) begin
         level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= '0;
         missed_q <= '0;
      end else begin
         level_q <= level_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
         if (ovf_evt && (ovf_q != '1))       ovf_q    <= ovf_q + CNT_WIDTH'(1);
         if (missed_evt && (missed_q != '1)) missed_q <= missed_q + CNT_WIDTH'(1);
      end
   end

   // Storage has no reset; outputs are gated by trace_valid instead.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_addr_q[wr_ptr_q]  <= addr_q;
         mem_t_req_q[wr_ptr_q] <= t_req_q;
         mem_t_gnt_q[wr_ptr_q] <= t_gnt_q;
         mem_t_rv_q[wr_ptr_q]  <= t_rv_q;
         mem_t_dec_q[wr_ptr_q] <= cnt_q;
      end
   end

   assign trace_valid    = (level_q != '0);
   assign trace_addr     = trace_valid ? mem_addr_q[rd_ptr_q]  : '0;
   assign trace_t_req    = trace_valid ? mem_t_req_q[rd_ptr_q] : '0;
   assign trace_t_gnt    = trace_valid ? mem_t_gnt_q[rd_ptr_q] : '0;
   assign trace_t_rvalid = trace_valid ? mem_t_rv_q[rd_ptr_q]  : '0;
   assign trace_t_dec    = trace_valid ? mem_t_dec_q[rd_ptr_q] : '0;
   assign fifo_level     = level_q;
   assign overflow_count = ovf_q;
   assign missed_count   = missed_q;

`ifdef TRACE_RDATA_EN
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (ld_rv) begin
         data_q <= instr_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_data_q[wr_ptr_q] <= data_q;
   end

   assign trace_data = trace_valid ? mem_data_q[rd_ptr_q] : '0;
`else
   logic unused_rdata;
   assign unused_rdata = ^instr_rdata;
   assign trace_data   = '0;
`endif

endmodule
